regfile_mp: RTL and testbench

- Parametrised successor to the 4x16 CPU register file. Generic data width and depth, two registered read ports, one write port.
- Adds a sequential bulk-clear engine, selectable write-to-read forwarding, and a read-valid strobe.
- Sits between the decode stage and the ALU. It feeds both ALU operands and takes the writeback result.

---
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised register file: two registered read ports, one write port, sequential bulk-clear engine.
// Build option: define REGFILE_BYPASS_EN for write-first forwarding; otherwise reads are read-first.
`timescale 1ns/1ps
module regfile_mp #(
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  localparam int               ADR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADR_W-1:0]  write_adr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADR_W-1:0]  read_adr1,
  input  logic [ADR_W-1:0]  read_adr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_valid,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              clear_state
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADR_W-1:0] LAST = ADR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  state_t            state;
  logic [ADR_W-1:0]  idx;

  logic              w_in, r1_in, r2_in;
  logic              write_ok, read_ok;
  logic [DATA_W-1:0] rd1_next, rd2_next;

  // Addresses at or beyond DEPTH only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << ADR_W)) begin : g_pow2
    assign w_in  = 1'b1;
    assign r1_in = 1'b1;
    assign r2_in = 1'b1;
  end else begin : g_npow2
    localparam logic [ADR_W:0] DEPTH_X = (ADR_W + 1)'(DEPTH);
    assign w_in  = {1'b0, write_adr} < DEPTH_X;
    assign r1_in = {1'b0, read_adr1} < DEPTH_X;
    assign r2_in = {1'b0, read_adr2} < DEPTH_X;
  end

  assign write_ok = write_en && (state == IDLE) && !clear_req && w_in;
  assign read_ok  = read_en && (state == IDLE);

  always_comb begin
    rd1_next = '0;
    rd2_next = '0;
    if (r1_in) rd1_next = regs[read_adr1];
    if (r2_in) rd2_next = regs[read_adr2];
`ifdef REGFILE_BYPASS_EN
    if (write_ok && (write_adr == read_adr1)) rd1_next = write_data;
    if (write_ok && (write_adr == read_adr2)) rd2_next = write_data;
`endif
  end

  // read_valid is a one-cycle strobe with no backpressure: read_data1/2 are fresh
  // exactly in the cycles where read_valid=1 and hold their last value otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      read_valid <= 1'b0;
      state      <= IDLE;
      idx        <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (write_ok) regs[write_adr] <= write_data;
      if (read_ok) begin
        read_data1 <= rd1_next;
        read_data2 <= rd2_next;
        read_valid <= 1'b1;
      end else begin
        read_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (clear_req) begin
            regs[0]    <= CLEAR_VAL;
            idx        <= ADR_W'(1);
            state      <= CLEAR;
            clear_done <= (LAST == ADR_W'(1));
          end
        end
        CLEAR: begin
          regs[idx] <= CLEAR_VAL;
          if (idx == LAST) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + ADR_W'(1);
            // done marks the cycle whose closing edge writes the last register
            clear_done <= ((idx + ADR_W'(1)) == LAST);
          end
        end
      endcase
    end
  end

  assign clear_busy  = (state == CLEAR);
  assign clear_state = state;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a DEPTH=4 and a DEPTH=5 instance share stimulus and are checked
// every cycle against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_mp;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        we, re, cr;
  logic [2:0]  wa, a1, a2;
  logic [15:0] wd;

  logic [15:0] rd1_4, rd2_4, rd1_5, rd2_5;
  logic        rv_4, rv_5, busy_4, busy_5, done_4, done_5, st_4, st_5;

  regfile_mp #(.DATA_W(16), .DEPTH(4), .CLEAR_VAL(16'h0000)) u_dut4 (
    .clk(clk), .reset(reset),
    .write_en(we), .write_adr(wa[1:0]), .write_data(wd),
    .read_en(re), .read_adr1(a1[1:0]), .read_adr2(a2[1:0]),
    .read_data1(rd1_4), .read_data2(rd2_4), .read_valid(rv_4),
    .clear_req(cr), .clear_busy(busy_4), .clear_done(done_4), .clear_state(st_4)
  );

  regfile_mp #(.DATA_W(16), .DEPTH(5), .CLEAR_VAL(16'h5A5A)) u_dut5 (
    .clk(clk), .reset(reset),
    .write_en(we), .write_adr(wa), .write_data(wd),
    .read_en(re), .read_adr1(a1), .read_adr2(a2),
    .read_data1(rd1_5), .read_data2(rd2_5), .read_valid(rv_5),
    .clear_req(cr), .clear_busy(busy_5), .clear_done(done_5), .clear_state(st_5)
  );

  // reference model: index 0 is the DEPTH=4 instance, index 1 the DEPTH=5 one
  int          n_cmp = 0;
  int          n_err = 0;
  int          dep [2] = '{4, 5};
  logic [15:0] cv  [2] = '{16'h0000, 16'h5A5A};
  logic [15:0] m_mem [2][8];
  logic [15:0] m_rd1 [2];
  logic [15:0] m_rd2 [2];
  logic        m_rv  [2];
  logic        m_clr [2];
  int          m_pos [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) m_mem[k][j] = 16'h0000;
      m_rd1[k] = 16'h0000;
      m_rd2[k] = 16'h0000;
      m_rv[k]  = 1'b0;
      m_clr[k] = 1'b0;
      m_pos[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int   w, r1, r2, d;
      logic wok;
      d   = dep[k];
      w   = int'(wa) & (k == 0 ? 3 : 7);
      r1  = int'(a1) & (k == 0 ? 3 : 7);
      r2  = int'(a2) & (k == 0 ? 3 : 7);
      wok = we && !m_clr[k] && !cr && (w < d);
      if (re && !m_clr[k]) begin
        m_rd1[k] = (r1 < d) ? m_mem[k][r1] : 16'h0000;
        m_rd2[k] = (r2 < d) ? m_mem[k][r2] : 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (wok && w == r1) m_rd1[k] = wd;
        if (wok && w == r2) m_rd2[k] = wd;
`endif
        m_rv[k] = 1'b1;
      end else begin
        m_rv[k] = 1'b0;
      end
      if (wok) m_mem[k][w] = wd;
      if (m_clr[k]) begin
        m_mem[k][m_pos[k]] = cv[k];
        if (m_pos[k] == d - 1) begin
          m_clr[k] = 1'b0;
          m_pos[k] = 0;
        end else begin
          m_pos[k]++;
        end
      end else if (cr) begin
        m_mem[k][0] = cv[k];
        m_clr[k]    = 1'b1;
        m_pos[k]    = 1;
      end
    end
  endtask

  // scoreboard: every output of both instances against the model
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] g1, g2;
      logic        gv, gb, gd, gs;
      string       p;
      p  = $sformatf("d%0d_", dep[k]);
      g1 = (k == 0) ? rd1_4  : rd1_5;
      g2 = (k == 0) ? rd2_4  : rd2_5;
      gv = (k == 0) ? rv_4   : rv_5;
      gb = (k == 0) ? busy_4 : busy_5;
      gd = (k == 0) ? done_4 : done_5;
      gs = (k == 0) ? st_4   : st_5;
      check_eq({p, "rd1"},   32'(g1), 32'(m_rd1[k]));
      check_eq({p, "rd2"},   32'(g2), 32'(m_rd2[k]));
      check_eq({p, "valid"}, 32'(gv), 32'(m_rv[k]));
      check_eq({p, "busy"},  32'(gb), 32'(m_clr[k]));
      check_eq({p, "done"},  32'(gd), 32'(m_clr[k] && (m_pos[k] == dep[k] - 1)));
      check_eq({p, "state"}, 32'(gs), 32'(m_clr[k]));
    end
  endtask

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic drive(input logic w_en, input logic [2:0] w_adr, input logic [15:0] w_dat,
                       input logic r_en, input logic [2:0] r1, input logic [2:0] r2,
                       input logic c_req);
    we = w_en; wa = w_adr; wd = w_dat;
    re = r_en; a1 = r1;    a2 = r2;
    cr = c_req;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_async_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    check_eq("areset_busy4", 32'(busy_4), 32'd0);
    check_eq("areset_rd1_4", 32'(rd1_4), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_clear(input string tag);
    int nb4, nb5, nd4, nd5;
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd4, 1'b1);
    nb4 = int'(busy_4); nb5 = int'(busy_5);
    nd4 = int'(done_4); nd5 = int'(done_5);
    for (int i = 0; i < 8; i++) begin
      drive(busy_4, 3'($urandom_range(0, 7)), 16'($urandom), 1'b1,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
      nb4 += int'(busy_4); nb5 += int'(busy_5);
      nd4 += int'(done_4); nd5 += int'(done_5);
    end
    check_eq({tag, "_busy_cycles4"}, 32'(nb4), 32'd3);
    check_eq({tag, "_busy_cycles5"}, 32'(nb5), 32'd4);
    check_eq({tag, "_done_pulses4"}, 32'(nd4), 32'd1);
    check_eq({tag, "_done_pulses5"}, 32'(nd5), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    we = 1'b0; re = 1'b0; cr = 1'b0;
    wa = '0; a1 = '0; a2 = '0; wd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b1;

    // first reads after reset
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd3, 1'b0);
    check_eq("tp1_rd1", 32'(rd1_4), 32'h0000);
    check_eq("tp1_rd2", 32'(rd2_4), 32'h0000);
    check_eq("tp1_valid", 32'(rv_4), 32'd1);

    // write then read on both ports, then hold
    drive(1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 1'b0);
    check_eq("beef_rd1", 32'(rd1_4), 32'hBEEF);
    check_eq("beef_rd2", 32'(rd2_4), 32'hBEEF);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
    check_eq("hold_rd1", 32'(rd1_4), 32'hBEEF);
    check_eq("hold_valid", 32'(rv_4), 32'd0);

    // same-edge write and read of one address
    drive(1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b1, 3'd1, 16'h1234, 1'b1, 3'd1, 3'd0, 1'b0);
`ifdef REGFILE_BYPASS_EN
    check_eq("fwd_rd1", 32'(rd1_4), 32'h1234);
`else
    check_eq("fwd_rd1", 32'(rd1_4), 32'hAAAA);
`endif
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd0, 1'b0);
    check_eq("after_fwd_rd1", 32'(rd1_4), 32'h1234);

    // fill, then clear with a concurrent read served from pre-clear data
    for (int i = 0; i < 5; i++) drive(1'b1, 3'(i), 16'hFFFF, 1'b0, 3'd0, 3'd0, 1'b0);
    run_clear("clr1");
    for (int i = 0; i < 8; i += 2) begin
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(i + 1), 1'b0);
      check_eq("clr1_rd1_zero", 32'(rd1_4), 32'h0000);
      check_eq("clr1_rd2_zero", 32'(rd2_4), 32'h0000);
    end

    // reset in the middle of a clear, after two clear writes
    for (int i = 0; i < 5; i++) drive(1'b1, 3'(i), 16'($urandom), 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
    do_async_reset();
    for (int i = 0; i < 8; i += 2) drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(i + 1), 1'b0);
    run_clear("clr2");

    // out-of-range addresses on the DEPTH=5 instance
    drive(1'b1, 3'd6, 16'h1111, 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd6, 1'b0);
    check_eq("oor_rd1_5", 32'(rd1_5), 32'h0000);
    check_eq("oor_rd2_5", 32'(rd2_5), 32'h0000);
    check_eq("oor_valid5", 32'(rv_5), 32'd1);

    // randomized traffic with occasional clears and asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] w, r1, r2;
      w  = 3'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? w : 3'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? w : 3'($urandom_range(0, 7));
      if (i % 700 == 350) do_async_reset();
      else drive(1'($urandom_range(0, 1)), w, 16'($urandom), ($urandom_range(0, 9) < 7),
                 r1, r2, ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
